dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter.sv | 72 +++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - two-port request/grant bus plus dmem side signals for dmem_arbiter
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_wren;
    logic [11:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_grant;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic        p1_wren;
    logic [11:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_grant;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;

    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;

    // master: requesters and the dmem macro; slave: the arbiter itself
    modport master (
        output p0_req, p0_wren, p0_addr, p0_wdata,
        input  p0_grant, p0_rvalid, p0_rdata,
        output p1_req, p1_wren, p1_addr, p1_wdata,
        input  p1_grant, p1_rvalid, p1_rdata,
        input  address_dmem, data, wren,
        output q_dmem
    );

    modport slave (
        input  p0_req, p0_wren, p0_addr, p0_wdata,
        output p0_grant, p0_rvalid, p0_rdata,
        input  p1_req, p1_wren, p1_addr, p1_wdata,
        output p1_grant, p1_rvalid, p1_rdata,
        output address_dmem, data, wren,
        input  q_dmem
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter in front of a single-port data memory
module dmem_arbiter (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    logic        r_last_granted;
    logic        r_p0_rvalid;
    logic        r_p1_rvalid;
    logic [31:0] r_p0_rdata;
    logic [31:0] r_p1_rdata;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_p0_read;
    logic        w_p1_read;

    // Contention goes to the port that did not win last; reset masks every grant.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            if (bus.p0_req && bus.p1_req) begin
                w_grant0 = r_last_granted;
                w_grant1 = ~r_last_granted;
            end else begin
                w_grant0 = bus.p0_req;
                w_grant1 = bus.p1_req;
            end
        end
    end

    assign w_p0_read = w_grant0 & ~bus.p0_wren;
    assign w_p1_read = w_grant1 & ~bus.p1_wren;

    assign bus.p0_grant     = w_grant0;
    assign bus.p1_grant     = w_grant1;
    assign bus.address_dmem = w_grant1 ? bus.p1_addr  : bus.p0_addr;
    assign bus.data         = w_grant1 ? bus.p1_wdata : bus.p0_wdata;
    assign bus.wren         = (w_grant0 & bus.p0_wren) | (w_grant1 & bus.p1_wren);

    // dmem runs on the inverted clock, so q_dmem is settled by the edge ending the grant cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_granted <= 1'b1;
            r_p0_rvalid    <= 1'b0;
            r_p1_rvalid    <= 1'b0;
            r_p0_rdata     <= 32'h0000_0000;
            r_p1_rdata     <= 32'h0000_0000;
        end else begin
            if (w_grant0) begin
                r_last_granted <= 1'b0;
            end else if (w_grant1) begin
                r_last_granted <= 1'b1;
            end
            r_p0_rvalid <= w_p0_read;
            r_p1_rvalid <= w_p1_read;
            if (w_p0_read) begin
                r_p0_rdata <= bus.q_dmem;
            end
            if (w_p1_read) begin
                r_p1_rdata <= bus.q_dmem;
            end
        end
    end

    // A read granted just before reset rises must not show rvalid while reset is held.
    assign bus.p0_rvalid = r_p0_rvalid & ~reset;
    assign bus.p1_rvalid = r_p1_rvalid & ~reset;
    assign bus.p0_rdata  = r_p0_rdata;
    assign bus.p1_rdata  = r_p1_rdata;
endmodule
